// File: rtl/kgp_multicycle_seq.sv
// rtl/kgp_multicycle_seq.sv - KGP-RISC multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB) with memory timeout.
// Optional retired-instruction counter enabled by KGP_SEQ_PERF_CNT_EN.
module kgp_multicycle_seq #(
    parameter logic [5:0] HALT_OP     = 6'b111111,
    parameter int         MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  branch,
    input  logic        reg_wr,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_load,
    output logic        pc_en,
    output logic        pc_src_branch,
    output logic        rf_we,
    output logic [2:0]  state,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [31:0] instr_retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // A zero timeout still needs a one-bit counter so the arithmetic stays legal.
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_MAX = CW'(MEM_TIMEOUT);
    localparam logic          TO_EN  = (MEM_TIMEOUT != 0);

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          timed_out;

    assign timed_out = TO_EN && (wait_q == TO_MAX);

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        ir_load       = 1'b0;
        pc_en         = 1'b0;
        pc_src_branch = 1'b0;
        rf_we         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_DECODE: begin
                state_d = (opcode == HALT_OP) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (branch != 2'b00) begin
                    pc_en         = 1'b1;
                    pc_src_branch = branch_taken;
                    state_d       = S_FETCH;
                    wait_d        = '0;
                end else if (mem_rd || mem_wr) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else if (reg_wr) begin
                    state_d = S_WB;
                end else begin
                    pc_en   = 1'b1;
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_wr;
                if (dmem_ready) begin
                    // Stores and loads without a destination retire straight from MEM.
                    if (mem_wr || !reg_wr) begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                        wait_d  = '0;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_en   = 1'b1;
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign state  = state_q;
    assign busy   = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
    assign halted = (state_q == S_HALT);
    assign err    = (state_q == S_ERR);

`ifdef KGP_SEQ_PERF_CNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (pc_en) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign instr_retired = retired_q;
`else
    assign instr_retired = 32'd0;
`endif

endmodule

// File: doc/kgp_multicycle_seq.md
# kgp_multicycle_seq

Multi-cycle instruction sequencer for the KGP-RISC core. It steps each instruction through fetch, decode, execute, memory and write-back, and handshakes with instruction and data memory. It gates the PC, IR, register-file and data-memory strobes using the static decode signals produced by the main control decoder. It sits between the IR/decoder and the datapath enables, and owns the only state machine in the core.

## Interface
- `HALT_OP`, `6'b111111`: opcode that stops the sequencer.
- `MEM_TIMEOUT`, `15`: maximum number of extra wait cycles per memory request; `0` disables the timeout.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin execution from IDLE.
- `opcode`  in  6  IR[31:26].
- `mem_rd`, `mem_wr`  in  1 each  decoder Memread / Memwrite.
- `branch`  in  2  decoder branch class; nonzero means a control-transfer instruction.
- `reg_wr`  in  1  decoder register-write request (any nonzero reg_write).
- `branch_taken`  in  1  datapath condition result, valid in EXEC.
- `imem_ready`, `dmem_ready`  in  1 each  memory acknowledge.
- `imem_req`, `dmem_req`  out  1 each  memory request, held until ready.
- `dmem_we`  out  1  data-memory write enable (valid with `dmem_req`).
- `ir_load`  out  1  IR capture strobe.
- `pc_en`  out  1  PC update strobe.
- `pc_src_branch`  out  1  select branch target (valid with `pc_en`).
- `rf_we`  out  1  register-file write strobe.
- `state`  out  3  current state encoding.
- `busy`  out  1  state is neither IDLE, HALT nor ERR.
- `halted`  out  1  state is HALT.
- `err`  out  1  state is ERR.
- `instr_retired`  out  32  retired-instruction count (see Configuration).

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- IDLE: all strobes 0. If `start`=1, go to FETCH.
- FETCH: `imem_req`=1. When `imem_ready`=1, `ir_load`=1 in the same cycle and go to DECODE.
- DECODE: if `opcode`==`HALT_OP`, go to HALT; otherwise go to EXEC.
- EXEC, evaluated in priority order:
  - `branch`!=0: `pc_en`=1, `pc_src_branch`=`branch_taken`, go to FETCH.
  - Otherwise, `mem_rd`|`mem_wr`: go to MEM.
  - Otherwise, `reg_wr`: go to WB.
  - Otherwise (undefined/NOP): `pc_en`=1, go to FETCH.
- MEM: `dmem_req`=1, `dmem_we`=`mem_wr`. A store that also has `mem_rd`=1 is treated as a store. On `dmem_ready`=1:
  - If `mem_wr` or !`reg_wr`: `pc_en`=1, go to FETCH.
  - Otherwise, go to WB.
- WB: `rf_we`=1, `pc_en`=1, go to FETCH.
- HALT and ERR are sticky; only `rst_n` leaves them, and `start` is ignored.
- Wait counter, width $clog2(`MEM_TIMEOUT`+1):
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle the relevant ready is low.
  - If ready is low while the counter equals `MEM_TIMEOUT` (and `MEM_TIMEOUT`!=0), go to ERR next cycle and drop the request.
  - Ready is honoured in any cycle up to and including that one, so at most `MEM_TIMEOUT`+1 request cycles occur.
- Decode inputs (`mem_rd`, `mem_wr`, `reg_wr`, `branch`) must stay stable from DECODE through WB; the IR does not change outside `ir_load`.

## Timing
- Strobes are combinational from the registered state plus the handshake inputs (`imem_ready`, `dmem_ready`, `branch_taken`). The state register, wait counter and `instr_retired` are the only flops.
- Reset (asynchronous, `rst_n`=0): `state`=IDLE, wait counter=0, `instr_retired`=0, and every output is 0.
  - Asserting reset mid-MEM or mid-FETCH drops the request immediately.
  - No `pc_en` or `rf_we` is issued for an aborted instruction.
- Latency with zero-wait memories (ready high in the request cycle):
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch or NOP: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- `start` is sampled only in IDLE. A one-cycle pulse is sufficient.

## Configuration
- `KGP_SEQ_PERF_CNT_EN` defined:
  - `instr_retired` increments by 1 in every cycle with `pc_en`=1.
  - It wraps from 32'hFFFFFFFF to 0.
  - It is cleared only by reset.
- Not defined: `instr_retired` is tied to 0, the port remains, and no counter flops are inferred.

## Test plan
- ALU op, `opcode`=000001, `reg_wr`=1, ready always high:
  - `state` sequence is 1,2,3,5,1.
  - `rf_we` and `pc_en` are 1 only in cycle 4.
  - `instr_retired` (with the macro defined) = 1.
- Load, `opcode`=100011, `dmem_ready` rising on the 3rd MEM cycle:
  - `dmem_req` is high for 3 cycles with `dmem_we`=0.
  - Then WB, with `rf_we`=1 for 1 cycle.
- Store, `mem_rd`=`mem_wr`=1, `reg_wr`=0:
  - `dmem_we`=1 during MEM.
  - `rf_we` is never asserted.
  - `pc_en` is issued in the MEM ack cycle.
- Branch, `branch`=2'b01:
  - With `branch_taken`=1: `pc_en`=`pc_src_branch`=1 in EXEC, then FETCH.
  - Repeat with `branch_taken`=0: `pc_src_branch`=0.
- Timeout, `MEM_TIMEOUT`=3, `dmem_ready` held low:
  - `dmem_req` is high for 4 cycles.
  - Then `state`=7 and `err`=1, stable until reset.
- `opcode`=111111 puts the sequencer in HALT (`halted`=1), and `start` pulses are ignored.
- `rst_n` pulsed low mid-MEM: outputs are 0 asynchronously, and `state` returns to IDLE.
